// File: rtl/modport_apb_pkg.sv
// Shared definitions for the APB register slave: register map, reset values
// and the address-decode select type.
package modport_apb_pkg;

    localparam logic [31:0] ADDR_CTRL = 32'h0000_0000;
    localparam logic [31:0] ADDR_REG1 = 32'h0000_0004;
    localparam logic [31:0] ADDR_REG2 = 32'h0000_0008;
    localparam logic [31:0] ADDR_REG3 = 32'h0000_000C;
    localparam logic [31:0] ADDR_ID   = 32'h0000_0010;

    localparam logic [31:0] RST_CTRL   = 32'h0000_0000;
    localparam logic [31:0] RST_REG    = 32'h0000_0000;
    localparam logic [31:0] RST_PRDATA = 32'h0000_0000;

    typedef enum logic [2:0] {
        SEL_CTRL,
        SEL_REG1,
        SEL_REG2,
        SEL_REG3,
        SEL_ID,
        SEL_NONE
    } reg_sel_e;

    // Full-width compare: unaligned addresses never match and fall to SEL_NONE.
    function automatic reg_sel_e decode_addr(input logic [31:0] addr);
        reg_sel_e sel;
        case (addr)
            ADDR_CTRL: sel = SEL_CTRL;
            ADDR_REG1: sel = SEL_REG1;
            ADDR_REG2: sel = SEL_REG2;
            ADDR_REG3: sel = SEL_REG3;
            ADDR_ID:   sel = SEL_ID;
            default:   sel = SEL_NONE;
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/modport_apb_slave.sv
// Zero-wait-state APB3 register slave: CTRL, three RW registers and a RO ID.
// Read data is registered in the setup phase and held until the next read.
module modport_apb_slave
    import modport_apb_pkg::*;
#(
    parameter logic [31:0] ID_VALUE = 32'hA5B0_0001,
    parameter int unsigned CTRL_W   = 4
) (
    input  logic        pclk,
    input  logic        presetn,
    input  logic        psel,
    input  logic        penable,
    input  logic        pwrite,
    input  logic [31:0] paddr,
    input  logic [31:0] pwdata,
    output logic [31:0] prdata
);

    reg_sel_e          sel;
    logic              wr_access;
    logic              rd_setup;
    logic              ctrl_we;
    logic              reg1_we;
    logic              reg2_we;
    logic              reg3_we;

    logic [CTRL_W-1:0] ctrl_q,   ctrl_d;
    logic [31:0]       reg1_q,   reg1_d;
    logic [31:0]       reg2_q,   reg2_d;
    logic [31:0]       reg3_q,   reg3_d;
    logic [31:0]       prdata_q, prdata_d;

    always_comb begin
        sel       = decode_addr(paddr);
        wr_access = psel & penable & pwrite;
        rd_setup  = psel & ~penable & ~pwrite;
        ctrl_we   = wr_access && (sel == SEL_CTRL);
        reg1_we   = wr_access && (sel == SEL_REG1);
        reg2_we   = wr_access && (sel == SEL_REG2);
        reg3_we   = wr_access && (sel == SEL_REG3);
    end

    always_comb begin
        ctrl_d   = ctrl_we ? pwdata[CTRL_W-1:0] : ctrl_q;
        reg1_d   = reg1_we ? pwdata : reg1_q;
        reg2_d   = reg2_we ? pwdata : reg2_q;
        reg3_d   = reg3_we ? pwdata : reg3_q;
        prdata_d = prdata_q;
        if (rd_setup) begin
            case (sel)
                SEL_CTRL: prdata_d = 32'(ctrl_q);
                SEL_REG1: prdata_d = reg1_q;
                SEL_REG2: prdata_d = reg2_q;
                SEL_REG3: prdata_d = reg3_q;
                SEL_ID:   prdata_d = ID_VALUE;
                default:  prdata_d = 32'h0000_0000;
            endcase
        end
    end

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            ctrl_q   <= RST_CTRL[CTRL_W-1:0];
            reg1_q   <= RST_REG;
            reg2_q   <= RST_REG;
            reg3_q   <= RST_REG;
            prdata_q <= RST_PRDATA;
        end else begin
            ctrl_q   <= ctrl_d;
            reg1_q   <= reg1_d;
            reg2_q   <= reg2_d;
            reg3_q   <= reg3_d;
            prdata_q <= prdata_d;
        end
    end

    assign prdata = prdata_q;

endmodule

// File: tb/tb_modport_apb_slave.sv
// Scoreboard bench for modport_apb_slave: expected read data is queued when a
// read is issued and compared against prdata sampled in the access phase.
module tb_modport_apb_slave;

    logic        pclk = 1'b0;
    logic        presetn = 1'b0;
    logic        psel = 1'b0;
    logic        penable = 1'b0;
    logic        pwrite = 1'b0;
    logic [31:0] paddr = 32'h0;
    logic [31:0] pwdata = 32'h0;
    logic [31:0] prdata;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_q[$];
    logic [31:0] mdl[4];

    localparam logic [31:0] ID_EXP = 32'hA5B0_0001;

    modport_apb_slave dut (
        .pclk    (pclk),
        .presetn (presetn),
        .psel    (psel),
        .penable (penable),
        .pwrite  (pwrite),
        .paddr   (paddr),
        .pwdata  (pwdata),
        .prdata  (prdata)
    );

    always #5 pclk = ~pclk;

    // Tasks are entered 1 time unit after a rising edge and leave the same way.
    task automatic apb_write(input logic [31:0] a, input logic [31:0] d);
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = a; pwdata = d;
        @(posedge pclk); #1;
        penable = 1'b1;
        @(posedge pclk); #1;
        penable = 1'b0;
    endtask

    task automatic apb_read(input logic [31:0] a, output logic [31:0] d);
        psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = a;
        @(posedge pclk); #1;
        penable = 1'b1;
        d = prdata;
        @(posedge pclk); #1;
        penable = 1'b0;
    endtask

    task automatic idle();
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
        @(posedge pclk); #1;
    endtask

    task automatic test_reset();
        logic [31:0] got, exp;
        logic [31:0] addrs[4] = '{32'h00, 32'h04, 32'h08, 32'h0C};
        // Load prdata with a nonzero value so the asynchronous clear is visible.
        apb_read(32'h10, got);
        idle();
        #3 presetn = 1'b0;
        #1;
        checks++;
        if (prdata !== 32'h0) begin
            errors++;
            $display("FAIL reset_prdata_async got %h exp %h", prdata, 32'h0);
        end
        @(posedge pclk); #1;
        presetn = 1'b1;
        for (int i = 0; i < 4; i++) mdl[i] = 32'h0;
        idle();
        for (int i = 0; i < 4; i++) begin
            exp_q.push_back(mdl[i]);
            apb_read(addrs[i], got);
            exp = exp_q.pop_front();
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL reset_reg%0d got %h exp %h", i, got, exp);
            end
            idle();
        end
        exp_q.push_back(ID_EXP);
        apb_read(32'h10, got);
        exp = exp_q.pop_front();
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL reset_id got %h exp %h", got, exp);
        end
        idle();
    endtask

    task automatic test_rw_roundtrip();
        logic [31:0] got, exp;
        logic [31:0] addrs[3] = '{32'h04, 32'h08, 32'h0C};
        logic [31:0] vals[3]  = '{32'hDEAD_BEEF, 32'h1234_5678, 32'hFFFF_FFFF};
        for (int i = 0; i < 3; i++) begin
            apb_write(addrs[i], vals[i]);
            mdl[i + 1] = vals[i];
            idle();
        end
        for (int i = 0; i < 3; i++) begin
            exp_q.push_back(mdl[i + 1]);
            apb_read(addrs[i], got);
            exp = exp_q.pop_front();
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL rw_roundtrip addr %h got %h exp %h", addrs[i], got, exp);
            end
            idle();
        end
    endtask

    task automatic test_ctrl_mask();
        logic [31:0] got, exp;
        apb_write(32'h00, 32'hFFFF_FFFF);
        mdl[0] = 32'h0000_000F;
        idle();
        exp_q.push_back(mdl[0]);
        apb_read(32'h00, got);
        exp = exp_q.pop_front();
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL ctrl_mask got %h exp %h", got, exp);
        end
        idle();
    endtask

    task automatic test_ignored();
        logic [31:0] got, exp;
        logic [31:0] addrs[4] = '{32'h10, 32'h20, 32'h05, 32'h04};
        logic [31:0] exps[4];
        exps = '{ID_EXP, 32'h0, 32'h0, mdl[1]};
        apb_write(32'h10, 32'h0);
        idle();
        apb_write(32'h20, 32'h55);
        idle();
        apb_write(32'h05, 32'h55);
        idle();
        for (int i = 0; i < 4; i++) begin
            exp_q.push_back(exps[i]);
            apb_read(addrs[i], got);
            exp = exp_q.pop_front();
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL ignored addr %h got %h exp %h", addrs[i], got, exp);
            end
            idle();
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] got, exp;
        apb_write(32'h04, 32'h0000_000A);
        mdl[1] = 32'h0000_000A;
        exp_q.push_back(mdl[1]);
        apb_read(32'h04, got);
        exp = exp_q.pop_front();
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL back_to_back got %h exp %h", got, exp);
        end
        idle();
    endtask

    task automatic test_penable_no_psel();
        logic [31:0] got, exp;
        logic [31:0] addrs[4] = '{32'h00, 32'h04, 32'h08, 32'h0C};
        for (int i = 0; i < 4; i++) begin
            psel = 1'b0; pwrite = 1'b1; paddr = addrs[i]; pwdata = 32'h0000_0077;
            penable = 1'b0;
            @(posedge pclk); #1;
            penable = 1'b1;
            @(posedge pclk); #1;
            penable = 1'b0; pwrite = 1'b0;
        end
        idle();
        for (int i = 0; i < 4; i++) begin
            exp_q.push_back(mdl[i]);
            apb_read(addrs[i], got);
            exp = exp_q.pop_front();
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL penable_no_psel addr %h got %h exp %h", addrs[i], got, exp);
            end
            idle();
        end
    endtask

    task automatic test_reset_mid_write();
        logic [31:0] got, exp;
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'h08; pwdata = 32'h99;
        @(posedge pclk); #1;
        penable = 1'b1;
        #2 presetn = 1'b0;
        @(posedge pclk); #1;
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
        @(posedge pclk); #1;
        presetn = 1'b1;
        for (int i = 0; i < 4; i++) mdl[i] = 32'h0;
        idle();
        exp_q.push_back(mdl[2]);
        apb_read(32'h08, got);
        exp = exp_q.pop_front();
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL reset_mid_write got %h exp %h", got, exp);
        end
        idle();
    endtask

    initial begin
        for (int i = 0; i < 4; i++) mdl[i] = 32'h0;
        repeat (2) @(posedge pclk);
        #1 presetn = 1'b1;
        idle();
        test_reset();
        test_rw_roundtrip();
        test_ctrl_mask();
        test_ignored();
        test_back_to_back();
        test_penable_no_psel();
        test_reset_mid_write();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
